// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: SPI master byte engine between a transmit FIFO and a
// receive FIFO. It pops one byte, shifts it out on mosi_o while
// assembling the byte seen on miso_i, then pushes the result.
//
// Optional feature macro: SPI_XFER_LSB_FIRST_EN adds the lsbf input
// (latched at byte start; 1 = bit 1 first). Without it transfers are
// always MSB-first.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   en                engine enable, sampled only while idle
//   cpol, cpha, div   SPI mode and SCK half-period (div+1 clk cycles)
//   tx_empty, tx_dout transmit FIFO flag and head data
//   tx_re             transmit FIFO pop strobe (combinational, cycle 0)
//   rx_full           receive FIFO full flag, checked at byte start only
//   rx_din, rx_we     received byte and push strobe
//   sck_o, mosi_o     SPI clock and data out (registered)
//   miso_i            SPI data in
//   busy, done        transfer in progress / end-of-byte pulse
module spi_xfer_engine #(
  parameter int unsigned DW   = 8,
  parameter int unsigned DIVW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            cpol,
  input  logic            cpha,
  input  logic [DIVW-1:0] div,
`ifdef SPI_XFER_LSB_FIRST_EN
  input  logic            lsbf,
`endif
  input  logic            tx_empty,
  input  logic [DW:1]     tx_dout,
  output logic            tx_re,
  input  logic            rx_full,
  output logic [DW:1]     rx_din,
  output logic            rx_we,
  output logic            sck_o,
  output logic            mosi_o,
  input  logic            miso_i,
  output logic            busy,
  output logic            done
);

  localparam int unsigned EW = $clog2(2 * DW + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DW);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

  state_t          state;
  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_q;
  logic [EW-1:0]   ecnt;
  logic            cpha_q;
  logic            samp;
  logic [DW:1]     tx_sh;
  logic [DW:1]     rx_sh;
  logic            lsb_in;
  logic            lsb_q;
  logic            start;
  logic            tick;
  logic [EW-1:0]   ek;
  logic            adv;

`ifdef SPI_XFER_LSB_FIRST_EN
  assign lsb_in = lsbf;
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  // Bit currently at the head of the shift register
  function automatic logic head(input logic [DW:1] d, input logic lsb);
    return lsb ? d[1] : d[DW];
  endfunction

  // Drop the head bit
  function automatic logic [DW:1] drop(input logic [DW:1] d, input logic lsb);
    return lsb ? {1'b0, d[DW:2]} : {d[DW-1:1], 1'b0};
  endfunction

  // Insert a received bit; the first bit received ends at the head position
  function automatic logic [DW:1] ins(input logic [DW:1] r, input logic b, input logic lsb);
    return lsb ? {b, r[DW:2]} : {r[DW-1:1], b};
  endfunction

  assign start = (state == IDLE) && en && !tx_empty && !rx_full;
  // Gated by rst so the pop strobe is low while reset is asserted
  assign tx_re = rst && start;

  // Divider phase: cnt holds cycle index mod (div+1); edge due at cnt == div
  assign tick = (cnt == div_q) && (ecnt != LAST);
  assign ek   = ecnt + EW'(1);
  // mosi advances on odd edges (cpha=1) or even edges except the last (cpha=0)
  assign adv  = cpha_q ? ek[0] : (!ek[0] && (ek != LAST));

  // Transfer FSM and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= '0;
      ecnt   <= '0;
      cpha_q <= 1'b0;
      samp   <= 1'b0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_din <= '0;
      rx_we  <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      sck_o  <= 1'b0;
      mosi_o <= 1'b0;
`ifdef SPI_XFER_LSB_FIRST_EN
      lsb_q  <= 1'b0;
`endif
    end else begin
      rx_we <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          sck_o <= cpol;
          if (start) begin
            state  <= SHIFT;
            busy   <= 1'b1;
            div_q  <= div;
            cpha_q <= cpha;
            rx_sh  <= '0;
`ifdef SPI_XFER_LSB_FIRST_EN
            lsb_q  <= lsb_in;
`endif
            if (div == '0) begin
              // Edge 1 is already due at this clock: toggle and drive bit 1
              sck_o  <= ~cpol;
              ecnt   <= EW'(1);
              cnt    <= '0;
              samp   <= ~cpha;
              mosi_o <= head(tx_dout, lsb_in);
              tx_sh  <= drop(tx_dout, lsb_in);
            end else begin
              ecnt <= '0;
              cnt  <= DIVW'(1);
              samp <= 1'b0;
              if (!cpha) begin
                mosi_o <= head(tx_dout, lsb_in);
                tx_sh  <= drop(tx_dout, lsb_in);
              end else begin
                tx_sh <= tx_dout;
              end
            end
          end
        end
        SHIFT: begin
          // Sample one cycle after the sampling edge became visible on sck_o
          if (samp) rx_sh <= ins(rx_sh, miso_i, lsb_q);
          samp <= 1'b0;
          if (ecnt == LAST) begin
            state  <= STORE;
            rx_we  <= 1'b1;
            done   <= 1'b1;
            rx_din <= samp ? ins(rx_sh, miso_i, lsb_q) : rx_sh;
          end else if (tick) begin
            sck_o <= ~sck_o;
            ecnt  <= ek;
            cnt   <= '0;
            samp  <= cpha_q ? !ek[0] : ek[0];
            if (adv) begin
              mosi_o <= head(tx_sh, lsb_q);
              tx_sh  <= drop(tx_sh, lsb_q);
            end
          end else begin
            cnt <= cnt + DIVW'(1);
          end
        end
        STORE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb_spi_xfer_engine: directed bench for spi_xfer_engine (DW=8, DIVW=4).
// A small array models the transmit FIFO; outputs are sampled on the
// falling clock edge, cycle 0 being the cycle in which tx_re is high.
module tb_spi_xfer_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [3:0] div = 4'd0;
`ifdef SPI_XFER_LSB_FIRST_EN
  logic       lsbf = 1'b0;
`endif
  logic       tx_empty;
  logic [7:0] tx_dout;
  logic       tx_re;
  logic       rx_full = 1'b0;
  logic [7:0] rx_din;
  logic       rx_we;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       busy;
  logic       done;
  logic       loop = 1'b0;
  logic       miso_v = 1'b0;

  logic [7:0] mem [0:15];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor results
  int         tog, first_tog, last_tog, we_cyc, we_cnt, tre, busy_lo;
  logic [7:0] bits, din;
  logic       done_at, mosi_c1;

  always #5 clk = ~clk;

  assign miso     = loop ? mosi : miso_v;
  assign tx_empty = (rp == wp);
  assign tx_dout  = mem[rp];

  always @(posedge clk) if (tx_re) rp <= rp + 4'd1;

  spi_xfer_engine #(.DW(8), .DIVW(4)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cpol(cpol),
    .cpha(cpha),
    .div(div),
`ifdef SPI_XFER_LSB_FIRST_EN
    .lsbf(lsbf),
`endif
    .tx_empty(tx_empty),
    .tx_dout(tx_dout),
    .tx_re(tx_re),
    .rx_full(rx_full),
    .rx_din(rx_din),
    .rx_we(rx_we),
    .sck_o(sck),
    .mosi_o(mosi),
    .miso_i(miso),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 4'd1;
  endtask

  // Observe cycles 1..n; captures mosi at the sampling edges of the mode
  task automatic mon(input int n, input logic samp_even);
    logic prev;
    prev = sck;
    tog = 0; first_tog = -1; last_tog = -1; we_cyc = -1; we_cnt = 0;
    tre = 0; busy_lo = 0; bits = 8'h00; din = 8'h00; done_at = 1'b0; mosi_c1 = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) mosi_c1 = mosi;
      if (sck !== prev) begin
        tog++;
        if (first_tog < 0) first_tog = c;
        last_tog = c;
        if (((tog % 2) == 0) == samp_even) bits = {bits[6:0], mosi};
      end
      prev = sck;
      if (rx_we === 1'b1) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc  = c;
          din     = rx_din;
          done_at = done;
        end
      end
      if (tx_re === 1'b1) tre++;
      if (busy !== 1'b1 && (we_cyc < 0 || we_cyc == c)) busy_lo++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #2;
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_tx_re", 32'(tx_re), 32'd0);
    chk("rst_rx_we", 32'(rx_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_din", 32'(rx_din), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0, div 0, A5 looped back
    loop = 1'b1; en = 1'b1;
    push(8'hA5);
    #1;
    chk("a5_tx_re_c0", 32'(tx_re), 32'd1);
    chk("a5_busy_c0", 32'(busy), 32'd0);
    mon(17, 1'b0);
    chk("a5_edges", 32'(tog), 32'd16);
    chk("a5_first_edge", 32'(first_tog), 32'd1);
    chk("a5_last_edge", 32'(last_tog), 32'd16);
    chk("a5_mosi_seq", 32'(bits), 32'hA5);
    chk("a5_we_cycle", 32'(we_cyc), 32'd17);
    chk("a5_rx_din", 32'(din), 32'hA5);
    chk("a5_done", 32'(done_at), 32'd1);
    chk("a5_busy_gaps", 32'(busy_lo), 32'd0);
    chk("a5_extra_pops", 32'(tre), 32'd0);
    @(negedge clk);
    chk("a5_mosi_hold", 32'(mosi), 32'd1);
    chk("a5_busy_c18", 32'(busy), 32'd0);
    chk("a5_sck_idle", 32'(sck), 32'd0);

    // Mode 3, div 3, 3C out, miso tied high
    loop = 1'b0; miso_v = 1'b1; cpol = 1'b1; cpha = 1'b1; div = 4'd3;
    @(negedge clk);
    @(negedge clk);
    chk("m3_sck_idle_hi", 32'(sck), 32'd1);
    push(8'h3C);
    #1;
    chk("m3_tx_re", 32'(tx_re), 32'd1);
    mon(66, 1'b1);
    chk("m3_edges", 32'(tog), 32'd16);
    chk("m3_first_edge", 32'(first_tog), 32'd4);
    chk("m3_last_edge", 32'(last_tog), 32'd64);
    chk("m3_mosi_seq", 32'(bits), 32'h3C);
    chk("m3_we_cycle", 32'(we_cyc), 32'd65);
    chk("m3_rx_din", 32'(din), 32'hFF);
    chk("m3_sck_end", 32'(sck), 32'd1);

    // div 1; config and en changed right after byte start
    loop = 1'b1; cpol = 1'b0; cpha = 1'b0; div = 4'd1;
    @(negedge clk);
    push(8'h96);
    push(8'h5A);
    #1;
    chk("cfg_tx_re", 32'(tx_re), 32'd1);
    @(posedge clk);
    #1;
    en = 1'b0; div = 4'd0; cpha = 1'b1; cpol = 1'b1;
    mon(33, 1'b0);
    chk("cfg_edges", 32'(tog), 32'd16);
    chk("cfg_first_edge", 32'(first_tog), 32'd2);
    chk("cfg_last_edge", 32'(last_tog), 32'd32);
    chk("cfg_mosi_seq", 32'(bits), 32'h96);
    chk("cfg_we_cycle", 32'(we_cyc), 32'd33);
    chk("cfg_rx_din", 32'(din), 32'h96);
    @(negedge clk);
    chk("en_off_no_pop", 32'(tx_re), 32'd0);
    chk("en_off_fifo", 32'(tx_empty), 32'd0);
    cpol = 1'b0; cpha = 1'b0;
    push(8'hC3);

    // Back-to-back bytes 5A, C3
    @(negedge clk);
    chk("en_off_no_pop2", 32'(tx_re), 32'd0);
    en = 1'b1;
    #1;
    chk("b2b_tx_re1", 32'(tx_re), 32'd1);
    mon(17, 1'b0);
    chk("b2b_we1_cycle", 32'(we_cyc), 32'd17);
    chk("b2b_rx_din1", 32'(din), 32'h5A);
    @(negedge clk);
    chk("b2b_tx_re2_c18", 32'(tx_re), 32'd1);
    chk("b2b_busy_c18", 32'(busy), 32'd0);
    mon(17, 1'b0);
    chk("b2b_busy_gaps2", 32'(busy_lo), 32'd0);
    chk("b2b_we2_cycle", 32'(we_cyc), 32'd17);
    chk("b2b_rx_din2", 32'(din), 32'hC3);
    chk("b2b_mosi_seq2", 32'(bits), 32'hC3);

    // rx_full blocks start; raising it mid-byte does not suppress rx_we
    @(negedge clk);
    rx_full = 1'b1;
    push(8'h3A);
    #1;
    chk("full_no_pop", 32'(tx_re), 32'd0);
    mon(4, 1'b0);
    chk("full_pops", 32'(tre), 32'd0);
    chk("full_sck_static", 32'(tog), 32'd0);
    @(posedge clk);
    #1;
    rx_full = 1'b0;
    @(negedge clk);
    chk("full_release_pop", 32'(tx_re), 32'd1);
    @(posedge clk);
    #1;
    rx_full = 1'b1;
    mon(17, 1'b0);
    chk("full_mid_we_cnt", 32'(we_cnt), 32'd1);
    chk("full_mid_we_cycle", 32'(we_cyc), 32'd17);
    chk("full_mid_rx_din", 32'(din), 32'h3A);

    // Reset at cycle 7 of a byte
    @(negedge clk);
    rx_full = 1'b0;
    push(8'hF0);
    push(8'h0F);
    #1;
    chk("rb_tx_re", 32'(tx_re), 32'd1);
    mon(6, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb_sck", 32'(sck), 32'd0);
    chk("rb_mosi", 32'(mosi), 32'd0);
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_tx_re_low", 32'(tx_re), 32'd0);
    chk("rb_rx_we", 32'(rx_we), 32'd0);
    chk("rb_done", 32'(done), 32'd0);
    chk("rb_rx_din", 32'(rx_din), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rb_hold_no_pop", 32'(tx_re), 32'd0);
    rst = 1'b1;
    #1;
    chk("rb_fresh_pop", 32'(tx_re), 32'd1);
    mon(17, 1'b0);
    chk("rb_we_cnt", 32'(we_cnt), 32'd1);
    chk("rb_we_cycle", 32'(we_cyc), 32'd17);
    chk("rb_rx_din", 32'(din), 32'h0F);

    // Maximum divider
    @(negedge clk);
    div = 4'hF;
    push(8'h81);
    #1;
    chk("dmax_tx_re", 32'(tx_re), 32'd1);
    mon(260, 1'b0);
    chk("dmax_edges", 32'(tog), 32'd16);
    chk("dmax_first_edge", 32'(first_tog), 32'd16);
    chk("dmax_last_edge", 32'(last_tog), 32'd256);
    chk("dmax_we_cycle", 32'(we_cyc), 32'd257);
    chk("dmax_rx_din", 32'(din), 32'h81);

    // Bit order with 01
    @(negedge clk);
    div = 4'd0;
`ifdef SPI_XFER_LSB_FIRST_EN
    lsbf = 1'b1;
`endif
    push(8'h01);
    #1;
    chk("ord_tx_re", 32'(tx_re), 32'd1);
    mon(17, 1'b0);
`ifdef SPI_XFER_LSB_FIRST_EN
    chk("ord_first_bit", 32'(mosi_c1), 32'd1);
    chk("ord_mosi_seq", 32'(bits), 32'h80);
`else
    chk("ord_first_bit", 32'(mosi_c1), 32'd0);
    chk("ord_mosi_seq", 32'(bits), 32'h01);
`endif
    chk("ord_rx_din", 32'(din), 32'h01);
    chk("ord_we_cycle", 32'(we_cyc), 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
